present_key_schedule: RTL and testbench
=======================================

PRESENT_KEY_SCHEDULE -- requirements
Module: present_key_schedule

Interface
REQ-001 SHALL have parameter key_size, default 80, master key width in bits.
REQ-002 SHALL have parameter size, default 64, round-key and block width in bits.
REQ-003 SHALL have parameter num_rounds, default 32, number of round keys emitted per schedule.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 start  input  1  request a new schedule; sampled only in IDLE.
REQ-007 orig_key  input  key_size  master key; sampled only on the accepted start cycle.
REQ-008 rk_ready  input  1  downstream encrypt datapath accepts the current round key.
REQ-009 rk_valid  output  1  round_key/round_idx are valid.
REQ-010 round_key  output  size  current round key, equal to key register bits [79:16].
REQ-011 round_idx  output  6  index of the current round key, 1..num_rounds.
REQ-012 busy  output  1  high in any state other than IDLE.
REQ-013 done  output  1  one-cycle pulse after the final round key is accepted.

Function
REQ-014 SHALL implement the FSM states IDLE and EMIT, with done registered as a single-cycle pulse.
REQ-015 In IDLE with start=1, SHALL load K<=orig_key, set cnt<=1, and go to EMIT on the next edge.
REQ-016 In EMIT, SHALL drive rk_valid=1, round_key=K[79:16], round_idx=cnt.
REQ-017 A handshake SHALL occur only on a rising edge where rk_valid=1 and rk_ready=1.
REQ-018 On a handshake with cnt<num_rounds, SHALL set K<=update(K,cnt) and cnt<=cnt+1, staying in EMIT, with no bubble cycle.
REQ-019 On a handshake with cnt==num_rounds, SHALL return to IDLE and assert done for exactly the following cycle.
REQ-020 update(K,i) SHALL be computed in order: (1) rotate K left by 61 bits, (2) replace bits [79:76] with S(bits[79:76]), (3) XOR i[4:0] into bits [19:15].
REQ-021 The S-box S, for inputs 0..F, SHALL be: C 5 6 B 9 0 A D 3 E F 8 4 7 1 2.
REQ-022 With rk_ready=0 in EMIT, SHALL hold K, cnt, round_key and round_idx stable, with rk_valid kept at 1 (no drop before acceptance).
REQ-023 SHALL ignore start while busy=1, including on the final handshake cycle; a new schedule starts only when start is seen in IDLE.
REQ-024 SHALL ignore changes to orig_key after the start cycle.
REQ-025 rk_valid SHALL be 0 in IDLE.
REQ-026 round_key and round_idx SHALL hold their last values in IDLE; they are don't-care for checking.
REQ-027 Exactly num_rounds handshakes SHALL occur per accepted start; round key 1 equals orig_key[79:16] unmodified.
REQ-028 cnt SHALL be 6 bits wide and never exceed num_rounds.

Reset
REQ-029 rst_n=0 SHALL asynchronously force state=IDLE, K=0, cnt=0, rk_valid=0, busy=0, done=0, round_key=0, round_idx=0.
REQ-030 Reset asserted mid-schedule SHALL abort the schedule with no further handshakes or done pulse.
REQ-031 After rst_n deasserts, the block SHALL accept start on the first rising edge.

Verification
REQ-032 Zero key: orig_key=0, start, rk_ready=1 -> round keys 1,2,3 = 0000000000000000, C000000000000000, 5000180000000001, with round_idx 1,2,3 on consecutive cycles.
REQ-033 Full run: any key, rk_ready=1 -> 32 consecutive handshakes with round_idx 1..32, done high exactly one cycle after idx 32, busy low thereafter; all keys match a reference model.
REQ-034 Backpressure: hold rk_ready=0 for 5 cycles at idx 7 -> rk_valid=1 with round_key/round_idx frozen, then idx 8 appears the cycle after rk_ready rises.
REQ-035 Start while busy: pulse start at idx 10 with a different orig_key -> schedule continues unchanged to idx 32; start asserted in the done cycle is ignored; start in the next IDLE cycle begins a new schedule.
REQ-036 Reset mid-operation: assert rst_n=0 at idx 15 -> outputs go to their reset values immediately; after release plus start with key FFFFFFFFFFFFFFFFFFFF, idx 1 round_key = FFFFFFFFFFFFFFFF.
REQ-037 Random rk_ready toggling over 100 schedules -> handshake sequence identical to the rk_ready=1 run, with no duplicate or skipped round_idx.

Source files
------------

// File: rtl/present_key_schedule.sv
// -----------------------------------------------------------------------------
// present_key_schedule
//
// PRESENT-80 round-key generator with a valid/ready output handshake.
// A start pulse seen while idle loads the master key. The block then presents
// num_rounds round keys, one per accepted handshake. Each handshake advances
// the 80-bit key register by one PRESENT key-update step, and the next round
// key follows with no bubble cycle. After the last key is accepted the block
// returns to idle and pulses done for one cycle.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request a new schedule (only honoured while idle)
//   orig_key   in   master key, captured on the accepted start cycle
//   rk_ready   in   downstream accepts the presented round key
//   rk_valid   out  round_key / round_idx are valid
//   round_key  out  key register bits [79:16]
//   round_idx  out  index of the presented round key, 1..num_rounds
//   busy       out  high whenever the block is not idle
//   done       out  single-cycle pulse after the final round key is accepted
// -----------------------------------------------------------------------------
module present_key_schedule #(
  parameter int key_size   = 80,
  parameter int size       = 64,
  parameter int num_rounds = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [key_size-1:0] orig_key,
  input  logic                rk_ready,
  output logic                rk_valid,
  output logic [size-1:0]     round_key,
  output logic [5:0]          round_idx,
  output logic                busy,
  output logic                done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_EMIT = 1'b1;

  // Rotation amount of the key update (left rotate).
  localparam int ROT = 61;

  localparam logic [5:0] LAST_IDX = 6'(num_rounds);

  logic [0:0]          state_q, state_d;
  logic [key_size-1:0] key_q,   key_d;
  logic [5:0]          cnt_q,   cnt_d;
  logic                done_q,  done_d;

  logic [key_size-1:0] key_rot;
  logic [key_size-1:0] key_next;
  logic                last_round;

  // PRESENT 4-bit S-box.
  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;
      4'h1: y = 4'h5;
      4'h2: y = 4'h6;
      4'h3: y = 4'hB;
      4'h4: y = 4'h9;
      4'h5: y = 4'h0;
      4'h6: y = 4'hA;
      4'h7: y = 4'hD;
      4'h8: y = 4'h3;
      4'h9: y = 4'hE;
      4'hA: y = 4'hF;
      4'hB: y = 4'h8;
      4'hC: y = 4'h4;
      4'hD: y = 4'h7;
      4'hE: y = 4'h1;
      default: y = 4'h2;
    endcase
    return y;
  endfunction

  // One key-update step: rotate left, substitute the top nibble, then mix
  // the round counter into bits [19:15]. The counter used is the index of
  // the key being accepted, so key i+1 = update(key i, i).
  always_comb begin
    key_rot  = {key_q[key_size-ROT-1:0], key_q[key_size-1:key_size-ROT]};
    key_next = key_rot;
    key_next[key_size-1 -: 4] = sbox(key_rot[key_size-1 -: 4]);
    key_next[19:15] = key_rot[19:15] ^ cnt_q[4:0];
  end

  assign last_round = (cnt_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The done cycle is idle but still belongs to the finished
        // schedule, so a start seen there is dropped.
        if (start && !done_q) begin
          key_d   = orig_key;
          cnt_d   = 6'd1;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (rk_ready) begin
          if (last_round) begin
            // Key register and counter keep the final values so the
            // outputs hold steady while idle.
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            key_d = key_next;
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      key_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // All outputs come straight from flops, so reset clears them at once.
  assign rk_valid  = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign round_key = key_q[key_size-1 -: size];
  assign round_idx = cnt_q;

endmodule

// File: tb/tb_present_key_schedule.sv
module tb_present_key_schedule;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [79:0] orig_key;
  logic        rk_ready;
  logic        rk_valid;
  logic [63:0] round_key;
  logic [5:0]  round_idx;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_rk  [1:32];
  logic [63:0] got_key [1:64];
  int          got_idx [1:64];
  int          got_cyc [1:64];
  int          n_hs, last_hs_cyc, done_cyc, done_cnt;

  present_key_schedule #(
    .key_size  (80),
    .size      (64),
    .num_rounds(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .orig_key (orig_key),
    .rk_ready (rk_ready),
    .rk_valid (rk_valid),
    .round_key(round_key),
    .round_idx(round_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running at time %0t, required finish earlier", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [3:0] ref_sbox(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [79:0] ref_update(input logic [79:0] k, input int i);
    logic [79:0] r;
    logic [4:0]  iv;
    for (int b = 0; b < 80; b++) r[(b + 61) % 80] = k[b];
    r[79:76] = ref_sbox(r[79:76]);
    iv = i[4:0];
    r[19:15] = r[19:15] ^ iv;
    return r;
  endfunction

  task automatic compute_exp(input logic [79:0] key);
    logic [79:0] k;
    k = key;
    exp_rk[1] = k[79:16];
    for (int i = 1; i < 32; i++) begin
      k = ref_update(k, i);
      exp_rk[i+1] = k[79:16];
    end
  endtask

  // ---------------- stimulus helpers (no checking) ----------------
  // Called at a negedge while idle; returns at the negedge showing idx 1.
  task automatic start_sched(input logic [79:0] key);
    start    = 1'b1;
    orig_key = key;
    @(negedge clk);
    start    = 1'b0;
    orig_key = ~key;
  endtask

  // Records handshakes from the current negedge until two cycles past done.
  task automatic collect(input bit rand_ready, input bit start_on_done,
                         input logic [79:0] next_key, input int max_cyc);
    bit pulsed;
    pulsed      = 1'b0;
    n_hs        = 0;
    last_hs_cyc = -1;
    done_cyc    = -1;
    done_cnt    = 0;
    for (int c = 0; c < max_cyc; c++) begin
      rk_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (start_on_done && done && !pulsed) begin
        start    = 1'b1;
        orig_key = next_key;
        pulsed   = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (rk_valid && rk_ready) begin
        n_hs++;
        if (n_hs <= 64) begin
          got_key[n_hs] = round_key;
          got_idx[n_hs] = int'(round_idx);
          got_cyc[n_hs] = c;
        end
        last_hs_cyc = c;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
      @(negedge clk);
    end
    rk_ready = 1'b0;
    start    = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; rk_ready = 1'b0; orig_key = '0;
    repeat (3) @(negedge clk);
    checks++; if (rk_valid !== 1'b0) begin errors++; $display("FAIL reset_rk_valid: got %b, want 0", rk_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, want 0", done); end
    checks++; if (round_key !== 64'h0) begin errors++; $display("FAIL reset_round_key: got %h, want 0", round_key); end
    checks++; if (round_idx !== 6'd0) begin errors++; $display("FAIL reset_round_idx: got %0d, want 0", round_idx); end
    rst_n = 1'b1;
    $display("reset: outputs sampled with rst_n low");
  endtask

  task automatic test_zero_key();
    logic [63:0] want [1:3];
    want[1] = 64'h0000000000000000;
    want[2] = 64'hC000000000000000;
    want[3] = 64'h5000180000000001;
    start_sched(80'h0);
    collect(1'b0, 1'b0, 80'h0, 200);
    for (int i = 1; i <= 3; i++) begin
      checks++;
      if (got_key[i] !== want[i] || got_idx[i] !== i) begin
        errors++;
        $display("FAIL zero_key_rk%0d: got key %h idx %0d, want key %h idx %0d", i, got_key[i], got_idx[i], want[i], i);
      end
      $display("zero_key: idx %0d key %h", got_idx[i], got_key[i]);
    end
    checks++;
    if (got_cyc[2] !== got_cyc[1] + 1 || got_cyc[3] !== got_cyc[2] + 1) begin
      errors++;
      $display("FAIL zero_key_consecutive: got cycles %0d %0d %0d, want consecutive", got_cyc[1], got_cyc[2], got_cyc[3]);
    end
  endtask

  task automatic test_full_run();
    logic [79:0] key;
    key = 80'h0123456789ABCDEF4C2B;
    compute_exp(key);
    start_sched(key);
    collect(1'b0, 1'b0, 80'h0, 200);
    checks++; if (n_hs !== 32) begin errors++; $display("FAIL full_run_count: got %0d handshakes, want 32", n_hs); end
    for (int i = 1; i <= 32; i++) begin
      checks++;
      if (got_key[i] !== exp_rk[i] || got_idx[i] !== i || (i > 1 && got_cyc[i] !== got_cyc[i-1] + 1)) begin
        errors++;
        $display("FAIL full_run_rk%0d: got key %h idx %0d, want key %h idx %0d back-to-back", i, got_key[i], got_idx[i], exp_rk[i], i);
      end
    end
    checks++;
    if (done_cyc < 0 || done_cyc !== last_hs_cyc + 1 || done_cnt !== 1) begin
      errors++;
      $display("FAIL full_run_done: got done at cycle %0d (%0d cycles), want cycle %0d for 1 cycle", done_cyc, done_cnt, last_hs_cyc + 1);
    end
    checks++; if (busy !== 1'b0 || rk_valid !== 1'b0) begin errors++; $display("FAIL full_run_idle: got busy %b rk_valid %b, want 0 0", busy, rk_valid); end
    $display("full_run: key %h, %0d handshakes, last key %h", key, n_hs, got_key[32]);
  endtask

  task automatic test_backpressure();
    logic [79:0] key;
    bit found;
    key   = 80'hA5A5_5A5A_F00F_0FF0_1234;
    found = 1'b0;
    compute_exp(key);
    start_sched(key);
    for (int c = 0; c < 100; c++) begin
      if (rk_valid && round_idx == 6'd7) begin found = 1'b1; break; end
      rk_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL backpressure_reach: got idx %0d, want 7 reached", round_idx); end
    rk_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (rk_valid !== 1'b1 || round_idx !== 6'd7 || round_key !== exp_rk[7]) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got valid %b idx %0d key %h, want 1 7 %h", c, rk_valid, round_idx, round_key, exp_rk[7]);
      end
    end
    rk_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (round_idx !== 6'd8 || round_key !== exp_rk[8]) begin
      errors++;
      $display("FAIL backpressure_resume: got idx %0d key %h, want 8 %h", round_idx, round_key, exp_rk[8]);
    end
    collect(1'b0, 1'b0, 80'h0, 200);
    checks++;
    if (n_hs !== 25 || got_idx[1] !== 8 || got_key[25] !== exp_rk[32] || done_cyc < 0) begin
      errors++;
      $display("FAIL backpressure_finish: got %0d handshakes first idx %0d done %0d, want 25 8 seen", n_hs, got_idx[1], done_cyc);
    end
    $display("backpressure: held idx 7 for 5 cycles, resumed at idx 8");
  endtask

  task automatic test_start_while_busy();
    logic [79:0] key_a, key_b, key_c;
    bit found;
    key_a = 80'h1111_2222_3333_4444_5555;
    key_b = 80'hDEAD_BEEF_CAFE_F00D_9876;
    key_c = 80'h0F1E_2D3C_4B5A_6978_8796;
    found = 1'b0;
    compute_exp(key_a);
    start_sched(key_a);
    for (int c = 0; c < 100; c++) begin
      if (rk_valid && round_idx == 6'd10) begin found = 1'b1; break; end
      rk_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL busy_start_reach: got idx %0d, want 10 reached", round_idx); end
    rk_ready = 1'b1; start = 1'b1; orig_key = key_b;
    @(negedge clk);
    start = 1'b0;
    collect(1'b0, 1'b1, key_b, 200);
    checks++; if (n_hs !== 22) begin errors++; $display("FAIL busy_start_count: got %0d handshakes, want 22", n_hs); end
    for (int j = 1; j <= 22; j++) begin
      checks++;
      if (got_idx[j] !== j + 10 || got_key[j] !== exp_rk[j + 10]) begin
        errors++;
        $display("FAIL busy_start_rk%0d: got idx %0d key %h, want %0d %h", j + 10, got_idx[j], got_key[j], j + 10, exp_rk[j + 10]);
      end
    end
    checks++;
    if (busy !== 1'b0 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL busy_start_done_cycle: got busy %b rk_valid %b, want 0 0", busy, rk_valid);
    end
    compute_exp(key_c);
    start_sched(key_c);
    collect(1'b0, 1'b0, 80'h0, 200);
    checks++;
    if (n_hs !== 32 || got_key[1] !== exp_rk[1] || got_key[32] !== exp_rk[32]) begin
      errors++;
      $display("FAIL busy_start_restart: got %0d hs key1 %h, want 32 %h", n_hs, got_key[1], exp_rk[1]);
    end
    $display("start_while_busy: ignored starts, restart gave %0d handshakes", n_hs);
  endtask

  task automatic test_reset_mid();
    logic [79:0] key;
    bit found;
    key   = 80'h13579BDF02468ACE1357;
    found = 1'b0;
    start_sched(key);
    for (int c = 0; c < 100; c++) begin
      if (rk_valid && round_idx == 6'd15) begin found = 1'b1; break; end
      rk_ready = 1'b1;
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL reset_mid_reach: got idx %0d, want 15 reached", round_idx); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (rk_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || round_key !== 64'h0 || round_idx !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got valid %b busy %b done %b key %h idx %0d, want all 0", rk_valid, busy, done, round_key, round_idx);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (rk_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: got valid %b done %b, want 0 0", rk_valid, done);
    end
    rk_ready = 1'b0;
    rst_n    = 1'b1;
    compute_exp(80'hFFFFFFFFFFFFFFFFFFFF);
    start_sched(80'hFFFFFFFFFFFFFFFFFFFF);
    collect(1'b0, 1'b0, 80'h0, 200);
    checks++;
    if (got_key[1] !== 64'hFFFFFFFFFFFFFFFF || got_idx[1] !== 1) begin
      errors++;
      $display("FAIL reset_mid_restart: got key %h idx %0d, want FFFFFFFFFFFFFFFF 1", got_key[1], got_idx[1]);
    end
    checks++;
    if (n_hs !== 32 || got_key[32] !== exp_rk[32]) begin
      errors++;
      $display("FAIL reset_mid_full: got %0d hs last %h, want 32 %h", n_hs, got_key[32], exp_rk[32]);
    end
    $display("reset_mid: aborted at idx 15, restart key1 %h", got_key[1]);
  endtask

  task automatic test_random_ready();
    logic [79:0] key;
    int bad;
    for (int s = 0; s < 100; s++) begin
      key = {16'($urandom), $urandom, $urandom};
      compute_exp(key);
      start_sched(key);
      collect(1'b1, 1'b0, 80'h0, 2000);
      checks++;
      if (n_hs !== 32 || done_cyc < 0 || done_cyc !== last_hs_cyc + 1) begin
        errors++;
        $display("FAIL random_sched%0d_count: got %0d hs done %0d, want 32 done at %0d", s, n_hs, done_cyc, last_hs_cyc + 1);
      end
      bad = 0;
      for (int i = 1; i <= 32; i++) begin
        checks++;
        if (got_idx[i] !== i || got_key[i] !== exp_rk[i]) begin
          errors++;
          bad++;
          $display("FAIL random_sched%0d_rk%0d: got idx %0d key %h, want %0d %h", s, i, got_idx[i], got_key[i], i, exp_rk[i]);
        end
      end
      $display("random: schedule %0d key %h handshakes %0d bad %0d", s, key, n_hs, bad);
    end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_zero_key();
    test_full_run();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid();
    test_random_ready();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
